// File: rtl/display_data_arbiter.sv
// Round-robin arbiter sharing the renderer's glyph bus between two producers, with a
// shadow register that commits on each v_sync rise. Optional macro: DISPLAY_CODE_CHECK_EN.
module display_data_arbiter #(
  parameter int DIGITS   = 11,
  parameter int CODE_W   = 4,
  parameter int MAX_CODE = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       v_sync,
  input  logic                       req0,
  input  logic [DIGITS*CODE_W-1:0]   data0,
  input  logic                       req1,
  input  logic [DIGITS*CODE_W-1:0]   data1,
  output logic                       ack0,
  output logic                       ack1,
  output logic [DIGITS*CODE_W-1:0]   num_data,
  output logic                       pending,
  output logic                       commit,
  output logic                       code_err
);

  localparam int W = DIGITS * CODE_W;
  localparam logic [CODE_W-1:0] MAX_CODE_L = CODE_W'(MAX_CODE);
`ifdef DISPLAY_CODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   num_data_q, num_data_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           commit_q, commit_d;
  logic           last_grant_q, last_grant_d;
  logic           vs_prev_q, vs_prev_d;
  logic           code_err_q, code_err_d;

  logic           eff_req0, eff_req1;
  logic           grant0, grant1, grant;
  logic           vs_rise;
  logic           code_bad;
  logic [W-1:0]   grant_data, clean_data;

  always_comb begin
    // A requester is masked during its own ack cycle so a held level request is not accepted twice.
    eff_req0   = req0 & ~ack0_q;
    eff_req1   = req1 & ~ack1_q;
    grant0     = eff_req0 & (~eff_req1 | last_grant_q);
    grant1     = eff_req1 & (~eff_req0 | ~last_grant_q);
    grant      = grant0 | grant1;
    vs_rise    = v_sync & ~vs_prev_q;
    grant_data = grant1 ? data1 : data0;

    clean_data = grant_data;
    code_bad   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (CHECK_EN && (grant_data[k*CODE_W +: CODE_W] > MAX_CODE_L)) begin
        clean_data[k*CODE_W +: CODE_W] = '0;
        code_bad = 1'b1;
      end
    end

    ack0_d       = grant0;
    ack1_d       = grant1;
    last_grant_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_grant_q);
    shadow_d     = grant ? clean_data : shadow_q;
    vs_prev_d    = v_sync;
    code_err_d   = code_err_q | (grant & code_bad);

    // The old shadow commits on the rise even when a new grant overwrites it in the same cycle.
    commit_d   = vs_rise & (state_q == PENDING);
    num_data_d = commit_d ? shadow_q : num_data_q;

    state_d = state_q;
    if (grant)
      state_d = PENDING;
    else if (commit_d)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      num_data_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      commit_q     <= 1'b0;
      last_grant_q <= 1'b1;
      vs_prev_q    <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      num_data_q   <= num_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      commit_q     <= commit_d;
      last_grant_q <= last_grant_d;
      vs_prev_q    <= vs_prev_d;
      code_err_q   <= code_err_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign num_data = num_data_q;
  assign pending  = (state_q == PENDING);
  assign commit   = commit_q;
  assign code_err = CHECK_EN ? code_err_q : 1'b0;

endmodule

// File: tb/tb_display_data_arbiter.sv
// Directed bench for display_data_arbiter: a vector table for handshake/commit ordering,
// plus hand sequences for long v_sync, glyph code checking and mid-handshake reset.
module tb_display_data_arbiter;

  localparam int W = 44;

  localparam logic [W-1:0] D0 = 44'h0_1234_5678_9A;
  localparam logic [W-1:0] DA = 44'h111_1111_1111;
  localparam logic [W-1:0] DB = 44'h222_2222_2222;
  localparam logic [W-1:0] CE = 44'h000_0000_F123;
`ifdef DISPLAY_CODE_CHECK_EN
  localparam logic [W-1:0] CE_EXP = 44'h000_0000_0123;
  localparam logic         CE_ERR = 1'b1;
`else
  localparam logic [W-1:0] CE_EXP = 44'h000_0000_F123;
  localparam logic         CE_ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, v_sync, req0, req1;
  logic [W-1:0] data0, data1;
  logic         ack0, ack1, pending, commit, code_err;
  logic [W-1:0] num_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         req0;
    logic         req1;
    logic         vs;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         ack0;
    logic         ack1;
    logic         pend;
    logic         commit;
    logic [W-1:0] num;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  display_data_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .v_sync   (v_sync),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .num_data (num_data),
    .pending  (pending),
    .commit   (commit),
    .code_err (code_err)
  );

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic a0, input logic a1, input logic p,
                              input logic c, input logic [W-1:0] n, input logic ce);
    check_val({tag, " ack0"}, W'(ack0), W'(a0));
    check_val({tag, " ack1"}, W'(ack1), W'(a1));
    check_val({tag, " pending"}, W'(pending), W'(p));
    check_val({tag, " commit"}, W'(commit), W'(c));
    check_val({tag, " num_data"}, num_data, n);
    check_val({tag, " code_err"}, W'(code_err), W'(ce));
  endtask

  task automatic add_vec(input logic rst, input logic r0, input logic r1, input logic vs,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic a0, input logic a1, input logic p, input logic c,
                         input logic [W-1:0] n);
    vec_t v;
    v.rst = rst; v.req0 = r0; v.req1 = r1; v.vs = vs; v.d0 = d0; v.d1 = d1;
    v.ack0 = a0; v.ack1 = a1; v.pend = p; v.commit = c; v.num = n;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst_n  = ~v.rst;
    req0   = v.req0;
    req1   = v.req1;
    v_sync = v.vs;
    data0  = v.d0;
    data1  = v.d1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ncommit;

    rst_n = 1'b0; v_sync = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

    //        rst r0 r1 vs  d0  d1    a0 a1 p  c  num
    add_vec(1, 0, 0, 0, '0, '0,   0, 0, 0, 0, '0);   // 0 reset
    add_vec(0, 1, 0, 0, D0, '0,   1, 0, 1, 0, '0);   // 1 single request
    add_vec(0, 0, 0, 0, D0, '0,   0, 0, 1, 0, '0);
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 1, D0);   // 3 first v_sync rise commits
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 0, D0);
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 0, 0, D0);
    add_vec(1, 0, 0, 0, '0, '0,   0, 0, 0, 0, '0);   // 6 reset again
    add_vec(0, 1, 1, 0, DA, DB,   1, 0, 1, 0, '0);   // 7 both: req0 wins first
    add_vec(0, 0, 1, 0, DA, DB,   0, 1, 1, 0, '0);
    add_vec(0, 0, 0, 0, DA, DB,   0, 0, 1, 0, '0);
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 1, DB);   // 10 only latest shadow commits
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 0, 0, DB);
    add_vec(0, 1, 1, 0, D0, DA,   1, 0, 1, 0, DB);   // 12 last_grant=1: req0 wins again
    add_vec(0, 0, 1, 0, D0, DA,   0, 1, 1, 0, DB);
    add_vec(0, 0, 0, 0, D0, DA,   0, 0, 1, 0, DB);
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 1, DA);
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 0, 0, DA);
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 0, DA);   // 17 rise while idle: no commit
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 0, 0, DA);
    add_vec(0, 1, 0, 0, D0, '0,   1, 0, 1, 0, DA);   // 19 held req masked in ack cycle
    add_vec(0, 1, 0, 0, D0, '0,   0, 0, 1, 0, DA);
    add_vec(0, 1, 0, 0, D0, '0,   1, 0, 1, 0, DA);
    add_vec(0, 0, 0, 0, D0, '0,   0, 0, 1, 0, DA);
    add_vec(0, 0, 1, 1, '0, DB,   0, 1, 1, 1, D0);   // 23 grant and rise together
    add_vec(0, 0, 0, 1, '0, DB,   0, 0, 1, 0, D0);
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 1, 0, D0);
    add_vec(0, 0, 0, 1, '0, '0,   0, 0, 0, 1, DB);
    add_vec(0, 0, 0, 0, '0, '0,   0, 0, 0, 0, DB);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i].ack0, vecs[i].ack1, vecs[i].pend,
                   vecs[i].commit, vecs[i].num, 1'b0);
    end

    // v_sync held high for two lines yields exactly one commit
    req0 = 1'b1; data0 = DA;
    @(negedge clk);
    check_output("long_vs grant", 1'b1, 1'b0, 1'b1, 1'b0, DB, 1'b0);
    req0 = 1'b0; v_sync = 1'b1;
    ncommit = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (commit === 1'b1) ncommit++;
    end
    check_val("long_vs commit count", W'(ncommit), W'(1));
    check_val("long_vs num_data", num_data, DA);
    check_val("long_vs pending", W'(pending), W'(0));
    v_sync = 1'b0;
    @(negedge clk);
    v_sync = 1'b1;
    @(negedge clk);
    check_output("idle_rise", 1'b0, 1'b0, 1'b0, 1'b0, DA, 1'b0);
    v_sync = 1'b0;
    @(negedge clk);

    // out-of-range glyph in slot 3
    req0 = 1'b1; data0 = CE;
    @(negedge clk);
    check_output("code grant", 1'b1, 1'b0, 1'b1, 1'b0, DA, CE_ERR);
    req0 = 1'b0; v_sync = 1'b1;
    @(negedge clk);
    check_output("code commit", 1'b0, 1'b0, 1'b0, 1'b1, CE_EXP, CE_ERR);
    repeat (3) @(negedge clk);
    check_output("code sticky", 1'b0, 1'b0, 1'b0, 1'b0, CE_EXP, CE_ERR);

    // asynchronous reset mid-frame while ack1 is in flight
    req1 = 1'b1; data1 = DB;
    @(posedge clk);
    #1;
    check_val("midreset ack1 before", W'(ack1), W'(1));
    rst_n = 1'b0;
    #1;
    check_output("midreset async", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rerequest", 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    req1 = 1'b0; v_sync = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_data_arbiter.md
Name: display_data_arbiter

Overview:
- Sits between the value producers (e.g. counter/clock logic) and the VGA digit renderer.
- Shares the 11-digit num_data bus between two requesters with a round-robin req/ack handshake.
- Buffers each accepted value in a shadow register. The renderer-facing bus changes only at the start of vertical sync, so every frame shows one value and never a torn mix.

Parameters:
- DIGITS, 11, number of glyph slots on the bus.
- CODE_W, 4, bits per glyph code; slot k occupies bits [k*CODE_W +: CODE_W].
- MAX_CODE, 10, highest valid glyph code (0-9 are digits, 10 is the separator glyph).

Ports:
- clk  input  1  system/pixel clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- v_sync  input  1  vertical sync from the display timing logic, active high, synchronous to clk.
- req0  input  1  requester 0 write request (level).
- data0  input  DIGITS*CODE_W  requester 0 value; must be stable while req0 is high.
- req1  input  1  requester 1 write request (level).
- data1  input  DIGITS*CODE_W  requester 1 value; must be stable while req1 is high.
- ack0  output  1  one-cycle accept pulse for requester 0.
- ack1  output  1  one-cycle accept pulse for requester 1.
- num_data  output  DIGITS*CODE_W  committed glyph codes to the renderer.
- pending  output  1  shadow holds a value not yet committed.
- commit  output  1  one-cycle pulse when num_data is updated.
- code_err  output  1  sticky flag for an out-of-range glyph code (see Optional Feature).

Behaviour:
Reset (rst_n low, asynchronous):
- num_data=0, shadow=0.
- pending=0, ack0=0, ack1=0, commit=0, code_err=0.
- v_sync_d=0.
- last_grant=1, so requester 0 wins first.

Arbitration (every cycle):
- eff_req_i = req_i & ~ack_i. A requester is masked in its ack cycle, so a held req is not double-accepted.
- Only one eff_req: that requester is granted.
- Both eff_req: grant the one that is not last_grant.
- On a grant: ack_i <= 1 next cycle, shadow <= data_i, last_grant <= i, pending <= 1.
- Latency: req sampled high at edge n gives ack high during cycle n+1. The shadow update is visible after edge n.
- Requesters drop req after seeing ack. A req still high in the cycle after ack is a new request.

Commit FSM:
- States: IDLE (pending=0) and PENDING (pending=1).
- v_sync is registered into v_sync_d. vs_rise = v_sync & ~v_sync_d.
- IDLE -> PENDING on a grant.
- PENDING on vs_rise: num_data <= shadow, commit <= 1, then to IDLE unless a grant occurs in the same cycle.
- vs_rise while IDLE: no change, commit stays 0.
- Grant and vs_rise in the same cycle: the old shadow commits, the new data enters the shadow, and the FSM stays in PENDING. The new value commits at the next vs_rise.
- Multiple grants before vs_rise: the latest shadow wins and earlier values are dropped silently.
- v_sync held high for many lines gives exactly one vs_rise.
- rst_n asserted mid-frame or mid-handshake: everything returns to reset values immediately. An in-flight ack is lost and the requester must re-request.

Width rules:
- Pure register transfers with no arithmetic on data.
- last_grant is 1 bit. The FSM is 1 bit, and pending equals the FSM state.

Optional Feature:
- Macro: DISPLAY_CODE_CHECK_EN.
- Defined:
  - On each grant, every slot of data_i with code > MAX_CODE is replaced by 0 in the shadow.
  - code_err is set to 1 and stays set until reset.
  - Valid slots pass unchanged.
  - Adds no latency.
- Not defined:
  - Codes pass unchanged to the shadow.
  - code_err is tied to 0.

Test Plan:
- Reset, then req0=1 with data0=44'h0_1234_5678_9A. Expected: ack0 pulses one cycle later and pending=1. num_data stays 0 until the first v_sync rise, then equals 44'h0_1234_5678_9A with commit pulsing one cycle.
- req0 and req1 high together after reset. Expected: ack0 first, ack1 the next cycle, and the shadow/num_data ends up as data1. Repeat with both high and last_grant=1: requester 0 wins again.
- Two grants (data0=44'h111..., then data1=44'h222...) before one v_sync rise. Expected: only 44'h222... is committed, with exactly one commit pulse.
- Grant in the same cycle as the v_sync rise. Expected: the old shadow commits, pending stays 1, and the new value commits at the next rise.
- v_sync high for 2 lines (1600 clocks) while PENDING. Expected: a single commit. A v_sync rise while IDLE gives no commit.
- With DISPLAY_CODE_CHECK_EN defined, write slot 3 = 4'hF. Expected: the committed slot 3 is 0 and code_err=1, holding until rst_n is pulsed low mid-frame, which clears all outputs.
